lsb_mem_ctrl: RTL and testbench



---
 rtl/lsb_mem_ctrl_pkg.sv | 18 +
 rtl/lsb_mem_ctrl_load_extend.sv | 17 +
 rtl/lsb_mem_ctrl.sv | 95 +++++++++
 tb/tb_lsb_mem_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/lsb_mem_ctrl_pkg.sv
// lsb_mem_ctrl_pkg: shared access codes, state encoding and constants for the data-side memory controller
package lsb_mem_ctrl_pkg;
    localparam int LSB_SIZE = 8;
    localparam int LSB_ID_WIDTH = $clog2(LSB_SIZE);
    localparam logic [2:0] F3_LB = 3'b000;
    localparam logic [2:0] F3_LH = 3'b001;
    localparam logic [2:0] F3_LW = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [1:0] IO_REGION = 2'b11;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    function automatic logic [2:0] access_bytes(input logic [1:0] size);
        return size == F3_LB[1:0] ? 3'd1 : size == F3_LH[1:0] ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/lsb_mem_ctrl_load_extend.sv
// lsb_mem_ctrl_load_extend: assembles captured load bytes and applies sign or zero extension
module lsb_mem_ctrl_load_extend
    import lsb_mem_ctrl_pkg::*;
#(
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic [3:0][7:0]          lanes,
    input  logic [FUNCT3_WIDTH-1:0]  funct3,
    output logic [31:0]              val
);
    logic sign;
    always_comb begin
        sign = ~funct3[2];
        val = funct3[1:0] == F3_LB[1:0] ? {{24{sign & lanes[0][7]}}, lanes[0]} :
              funct3[1:0] == F3_LH[1:0] ? {{16{sign & lanes[1][7]}}, lanes[1], lanes[0]} : lanes;
    end
endmodule

// File: rtl/lsb_mem_ctrl.sv
// lsb_mem_ctrl: serialises one LSB load/store at a time onto the byte-wide RAM/IO bus
module lsb_mem_ctrl
    import lsb_mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int VAL_WIDTH    = 32,
    parameter int FUNCT3_WIDTH = 3
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     lsb2mem_en,
    input  logic                     lsb2mem_store_load,
    input  logic [ADDR_WIDTH-1:0]    lsb2mem_addr,
    input  logic [FUNCT3_WIDTH-1:0]  lsb2mem_type,
    input  logic [VAL_WIDTH-1:0]     lsb2mem_val,
    input  logic [LSB_ID_WIDTH-1:0]  lsb2mem_load_id,
    output logic                     mem_busy,
    output logic                     mem2lsb_load_en,
    output logic [LSB_ID_WIDTH-1:0]  mem2lsb_load_id,
    output logic [VAL_WIDTH-1:0]     mem2lsb_load_val,
    input  logic [7:0]               mem_din,
    output logic [7:0]               mem_dout,
    output logic [ADDR_WIDTH-1:0]    mem_a,
    output logic                     mem_wr,
    input  logic                     io_buffer_full
);
    state_t                   state;
    logic [ADDR_WIDTH-1:0]    addr, cur_a, prev_a;
    logic [3:0][7:0]          wdata, lanes;
    logic [LSB_ID_WIDTH-1:0]  id;
    logic [FUNCT3_WIDTH-1:0]  f3;
    logic [2:0]               n, cnt;
    logic [31:0]              ext_val;
    logic                     stall;

    assign cur_a = addr + ADDR_WIDTH'(cnt);
    assign prev_a = cur_a - ADDR_WIDTH'(1);
    assign stall = io_buffer_full && cur_a[17:16] == IO_REGION;
    assign mem_busy = state != IDLE;
    assign mem_wr = state == WRITE && rdy_in && !stall;
    assign mem_dout = state == WRITE ? wdata[cnt[1:0]] : 8'd0;
    // While frozen in READ, re-present the last issued address so mem_din still carries
    // the byte owed to the pending capture when rdy_in returns.
    assign mem_a = state == WRITE ? cur_a :
                   state != READ ? '0 :
                   rdy_in ? (cnt < n ? cur_a : '0) :
                   (cnt != 3'd0 ? prev_a : '0);
    assign mem2lsb_load_en = state == DONE && rdy_in;
    assign mem2lsb_load_id = mem2lsb_load_en ? id : '0;
    assign mem2lsb_load_val = mem2lsb_load_en ? VAL_WIDTH'(ext_val) : '0;

    lsb_mem_ctrl_load_extend #(.FUNCT3_WIDTH(FUNCT3_WIDTH)) u_ext (
        .lanes  (lanes),
        .funct3 (f3),
        .val    (ext_val)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            addr <= '0;
            wdata <= '0;
            lanes <= '0;
            id <= '0;
            f3 <= '0;
            n <= '0;
            cnt <= '0;
        end else if (rdy_in) begin
            case (state)
                IDLE: if (lsb2mem_en) begin
                    state <= lsb2mem_store_load ? WRITE : READ;
                    addr <= lsb2mem_addr;
                    wdata <= 32'(lsb2mem_val);
                    lanes <= '0;
                    id <= lsb2mem_load_id;
                    f3 <= lsb2mem_type;
                    n <= access_bytes(lsb2mem_type[1:0]);
                    cnt <= '0;
                end
                READ: begin
                    if (cnt != 3'd0) lanes[2'(cnt - 3'd1)] <= mem_din;
                    cnt <= cnt + 3'd1;
                    if (cnt == n) state <= DONE;
                end
                WRITE: if (!stall) begin
                    cnt <= cnt + 3'd1;
                    if (cnt == n - 3'd1) state <= IDLE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// tb_lsb_mem_ctrl: scoreboard bench with a cycle-schedule reference model of loads and stores
module tb_lsb_mem_ctrl;
    localparam int MAXC = 4096;
    logic clk = 1'b0;
    logic rst_in, rdy_in, lsb2mem_en, lsb2mem_store_load, io_buffer_full;
    logic [31:0] lsb2mem_addr, lsb2mem_val, mem2lsb_load_val, mem_a;
    logic [2:0] lsb2mem_type, lsb2mem_load_id, mem2lsb_load_id;
    logic mem_busy, mem2lsb_load_en, mem_wr;
    logic [7:0] mem_din = 8'd0;
    logic [7:0] mem_dout;
    int cyc = 0;
    int tests = 0;
    int fails = 0;
    bit rdy_s [MAXC];
    bit full_s [MAXC];
    logic [7:0] ram [logic [31:0]];
    typedef struct { logic [31:0] a; logic [31:0] d; int c; } ev_t;
    ev_t ld_q[$];
    ev_t wr_q[$];

    lsb_mem_ctrl dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .lsb2mem_en(lsb2mem_en), .lsb2mem_store_load(lsb2mem_store_load),
        .lsb2mem_addr(lsb2mem_addr), .lsb2mem_type(lsb2mem_type),
        .lsb2mem_val(lsb2mem_val), .lsb2mem_load_id(lsb2mem_load_id),
        .mem_busy(mem_busy), .mem2lsb_load_en(mem2lsb_load_en),
        .mem2lsb_load_id(mem2lsb_load_id), .mem2lsb_load_val(mem2lsb_load_val),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : a[7:0] ^ a[15:8] ^ 8'h5a;
    endfunction

    always @(posedge clk) mem_din <= rd(mem_a);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (mem2lsb_load_en) begin
                if (ld_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL load_unexpected: id %0d val %h at cycle %0d, none expected", mem2lsb_load_id, mem2lsb_load_val, cyc);
                end else begin
                    e = ld_q.pop_front();
                    check("load_id", 32'(mem2lsb_load_id), e.a);
                    check("load_val", mem2lsb_load_val, e.d);
                    check("load_cycle", cyc, e.c);
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL write_unexpected: addr %h data %h at cycle %0d, none expected", mem_a, mem_dout, cyc);
                end else begin
                    e = wr_q.pop_front();
                    check("write_addr", mem_a, e.a);
                    check("write_data", 32'(mem_dout), e.d);
                    check("write_cycle", cyc, e.c);
                end
            end
        end
    end

    initial begin
        #(MAXC * 10);
        $display("FAIL timeout: run did not finish within %0d cycles", MAXC);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
        rdy_in = rdy_s[cyc % MAXC];
        io_buffer_full = full_s[cyc % MAXC];
    endtask

    task automatic run_op(input bit st, input logic [31:0] a, input logic [2:0] t, input logic [31:0] v,
                          input logic [2:0] id, input int ext_en, input int rst_at);
        int n, c0, tc, idle_c;
        int rc[4];
        logic [31:0] ra[4];
        logic [31:0] raw, ex, ak;
        step();
        n = t[1:0] == 2'b00 ? 1 : t[1:0] == 2'b01 ? 2 : 4;
        lsb2mem_en = 1'b1; lsb2mem_store_load = st; lsb2mem_addr = a;
        lsb2mem_type = t; lsb2mem_val = v; lsb2mem_load_id = id;
        for (int k = 0; k < 4; k++) rc[k] = -1;
        c0 = cyc;
        while (!rdy_s[c0] && c0 < MAXC - 1) c0++;
        tc = c0 + 1;
        if (st) begin
            for (int k = 0; k < n; k++) begin
                ak = a + 32'(k);
                while ((!rdy_s[tc] || (full_s[tc] && ak[17:16] == 2'b11)) && tc < MAXC - 1) tc++;
                if (rst_at == 0 || tc <= c0 + rst_at) wr_q.push_back('{ak, (v >> (8 * k)) & 32'hff, tc});
                rc[k] = tc; ra[k] = ak;
                tc++;
            end
            idle_c = tc;
        end else begin
            raw = 0;
            for (int k = 0; k < n; k++) raw = raw | (32'(rd(a + 32'(k))) << (8 * k));
            ex = (!t[2] && n < 4 && raw[8 * n - 1]) ? raw | (32'hffffffff << (8 * n)) : raw;
            for (int s = 0; s <= n; ) begin
                if (rdy_s[tc]) begin
                    if (s < n) begin rc[s] = tc; ra[s] = a + 32'(s); end
                    s++;
                end
                tc++;
            end
            while (!rdy_s[tc] && tc < MAXC - 1) tc++;
            ld_q.push_back('{32'(id), ex, tc});
            idle_c = tc + 1;
        end
        if (rst_at != 0) idle_c = c0 + rst_at + 1;
        forever begin
            @(negedge clk);
            check("busy", 32'(mem_busy), 32'(cyc > c0 && cyc < idle_c));
            for (int k = 0; k < 4; k++)
                if (cyc == rc[k] && cyc < idle_c) begin
                    check("addr_seq", mem_a, ra[k]);
                    if (!st) check("load_no_wr", 32'(mem_wr), 0);
                end
            if (cyc == idle_c)
                check("idle_outputs", 32'((mem_a | 32'(mem_dout) | 32'(mem_wr) | 32'(mem2lsb_load_en) |
                      mem2lsb_load_val | 32'(mem2lsb_load_id)) != 0), 0);
            if (cyc >= idle_c) break;
            step();
            lsb2mem_en = (cyc <= c0) || (ext_en != 0 && cyc == c0 + ext_en);
            rst_in = rst_at != 0 && cyc == c0 + rst_at;
        end
    endtask

    initial begin
        logic [31:0] a;
        for (int i = 0; i < MAXC; i++) begin rdy_s[i] = 1'b1; full_s[i] = 1'b0; end
        rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0; lsb2mem_en = 1'b0;
        lsb2mem_store_load = 1'b0; lsb2mem_addr = '0; lsb2mem_type = '0;
        lsb2mem_val = '0; lsb2mem_load_id = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_busy", 32'(mem_busy), 0);
        check("rst_load_en", 32'(mem2lsb_load_en), 0);
        check("rst_load_id", 32'(mem2lsb_load_id), 0);
        check("rst_load_val", mem2lsb_load_val, 0);
        check("rst_mem_a", mem_a, 0);
        check("rst_mem_dout", 32'(mem_dout), 0);
        check("rst_mem_wr", 32'(mem_wr), 0);
        step();
        rst_in = 1'b0;
        ram[32'h1000] = 8'h78; ram[32'h1001] = 8'h56; ram[32'h1002] = 8'h34; ram[32'h1003] = 8'h12;
        run_op(0, 32'h1000, 3'b010, 0, 3'd5, 0, 0);
        ram[32'h40] = 8'h80;
        run_op(0, 32'h40, 3'b000, 0, 3'd1, 0, 0);
        run_op(0, 32'h40, 3'b100, 0, 3'd2, 0, 0);
        ram[32'h50] = 8'h01; ram[32'h51] = 8'h80;
        run_op(0, 32'h50, 3'b001, 0, 3'd3, 0, 0);
        run_op(0, 32'h50, 3'b101, 0, 3'd4, 0, 0);
        run_op(1, 32'h2000, 3'b010, 32'hdeadbeef, 3'd0, 0, 0);
        for (int i = 2; i <= 4; i++) full_s[cyc + i] = 1'b1;
        run_op(1, 32'h30000, 3'b000, 32'h41, 3'd0, 0, 0);
        run_op(0, 32'h1000, 3'b010, 0, 3'd6, 2, 0);
        rdy_s[cyc + 3] = 1'b0; rdy_s[cyc + 4] = 1'b0;
        run_op(0, 32'h1000, 3'b010, 0, 3'd7, 0, 0);
        run_op(1, 32'h3000, 3'b010, 32'hcafef00d, 3'd0, 0, 3);
        run_op(0, 32'hfffffffe, 3'b010, 0, 3'd2, 0, 0);
        run_op(1, 32'h3fffe, 3'b001, 32'h1234, 3'd0, 0, 0);
        for (int r = 0; r < 40; r++) begin
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a[17:16] = 2'b11;
            for (int k = 0; k < 4; k++) ram[a + 32'(k)] = 8'($urandom);
            for (int i = 1; i <= 40; i++) begin
                rdy_s[cyc + i] = $urandom_range(0, 4) != 0;
                full_s[cyc + i] = $urandom_range(0, 2) == 0;
            end
            run_op(1'($urandom), a, 3'($urandom), $urandom, 3'($urandom), 0, 0);
        end
        repeat (5) step();
        @(negedge clk);
        check("load_queue_empty", ld_q.size(), 0);
        check("write_queue_empty", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
